// File: rtl/fifo_param.sv
// Synchronous single-clock FIFO. It has a registered read port, occupancy count, threshold flags
// and sticky overflow/underflow error flags.
module fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Flags decode only the registered count, so no request input reaches them.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // When full, a write is allowed if a read frees the slot on the same edge.
    assign wr_acc = wr & (~full | rd);
    assign rd_acc = rd & ~empty;

    // Storage is never reset. The pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (reset_n && !clear && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            count <= count + CW'(wr_acc) - CW'(rd_acc);
            if (wr && full && !rd) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param. The driver predicts read data into a queue, and a negedge
// monitor pops each entry and compares it against data_out.
module tb_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned CW    = 6;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             clear = 1'b0;
    logic             wr = 1'b0;
    logic             rd = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0]    count;

    fifo_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AF_LEVEL(DEPTH - 4),
        .AE_LEVEL(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .clear(clear),
        .wr(wr),
        .data_in(data_in),
        .rd(rd),
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] mdout = '0;
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    bit               pending = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_flags(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, int'(count), n);
        chk({tag, ".full"}, int'(full), int'(n == 32));
        chk({tag, ".empty"}, int'(empty), int'(n == 0));
        chk({tag, ".almost_full"}, int'(almost_full), int'(n >= 28));
        chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= 4));
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(m_unf));
    endtask

    // One clock of stimulus. The model is updated on the same edge the DUT samples.
    task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d,
                        input bit c, input string tag);
        bit wacc, racc;
        wr = w; rd = r; data_in = d; clear = c;
        @(posedge clock);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wacc = w && (mq.size() < 32 || r);
            racc = r && (mq.size() > 0);
            if (w && mq.size() == 32 && !r) m_ovf = 1'b1;
            if (r && mq.size() == 0) m_unf = 1'b1;
            if (racc) begin
                exp_q.push_back(mq.pop_front());
                pending = 1'b1;
            end
            if (wacc) mq.push_back(d);
        end
        #1;
        chk_flags(tag);
        wr = 1'b0; rd = 1'b0; clear = 1'b0;
    endtask

    // Monitor: it takes the expected word when a read completes. Otherwise data_out must hold.
    always @(negedge clock) begin
        if (pending) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: actual=pending required=queued_word");
            end else begin
                mdout = exp_q.pop_front();
            end
            pending = 1'b0;
        end
        chk("data_out", int'(data_out), int'(mdout));
    end

    initial begin
        #1 reset_n = 1'b0;
        #11;
        chk_flags("reset");
        chk("reset.data_out", int'(data_out), 0);
        #1 reset_n = 1'b1;

        // Fill to full with 0x00..0x1F
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, WIDTH'(i), 1'b0, "fill");
        chk("fill.full", int'(full), 1);
        // Rejected write while full
        step(1'b1, 1'b0, 8'hAA, 1'b0, "ovf");
        step(1'b0, 1'b0, 8'h00, 1'b0, "ovf_sticky");
        // Drain. 0xAA must never appear.
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain");
        step(1'b0, 1'b0, 8'h00, 1'b0, "idle");

        // Empty with simultaneous rd/wr: only the write is taken
        step(1'b1, 1'b1, 8'h55, 1'b0, "empty_rw");
        step(1'b0, 1'b0, 8'h00, 1'b0, "empty_rw_hold");
        step(1'b0, 1'b1, 8'h00, 1'b0, "rd55");
        step(1'b0, 1'b0, 8'h00, 1'b0, "rd55_lat");

        // Full with simultaneous rd/wr across a pointer wrap
        step(1'b0, 1'b0, 8'h00, 1'b1, "clr1");
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, WIDTH'(8'h40 + i), 1'b0, "fill2");
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, WIDTH'(8'h80 + i), 1'b0, "full_rw");
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain2");
        step(1'b0, 1'b0, 8'h00, 1'b0, "idle2");

        // Count 10 with overflow set, then clear with a concurrent write
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, WIDTH'(8'hC0 + i), 1'b0, "fill3");
        step(1'b1, 1'b0, 8'hEE, 1'b0, "ovf3");
        for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "to10");
        chk("to10.count", int'(count), 10);
        step(1'b1, 1'b0, 8'h77, 1'b1, "clear_wr");
        step(1'b0, 1'b0, 8'h00, 1'b0, "after_clear");

        // Asynchronous reset between edges with 5 entries held
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(8'h20 + i), 1'b0, "fill5");
        step(1'b0, 1'b1, 8'h00, 1'b0, "rd20");
        step(1'b0, 1'b0, 8'h00, 1'b0, "rd20_lat");
        #1 reset_n = 1'b0;
        mq.delete(); exp_q.delete();
        mdout = '0; m_ovf = 1'b0; m_unf = 1'b0; pending = 1'b0;
        #1;
        chk_flags("async_rst");
        chk("async_rst.data_out", int'(data_out), 0);
        #1 reset_n = 1'b1;
        step(1'b1, 1'b0, 8'h11, 1'b0, "post_rst_wr");
        step(1'b0, 1'b1, 8'h00, 1'b0, "post_rst_rd");
        step(1'b0, 1'b0, 8'h00, 1'b0, "post_rst_lat");
        @(posedge clock);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
